// File: rtl/alu_operand_stage_if.sv
// alu_operand_stage_if: request, forwarding and registered-operand bundle for alu_operand_stage.
interface alu_operand_stage_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 4,
    parameter int NUM_FWD = 2,
    parameter int REG_AW  = 5,
    parameter int CNT_W   = 16,
    parameter int SEL_W   = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1
);
    logic                       in_valid;
    logic                       in_ready;
    logic [SEL_W-1:0]           sel;
    logic [NUM_SRC*WIDTH-1:0]   src;
    logic [REG_AW-1:0]          rs_addr;
    logic [NUM_FWD-1:0]         fwd_valid;
    logic [NUM_FWD-1:0]         fwd_busy;
    logic [NUM_FWD*REG_AW-1:0]  fwd_addr;
    logic [NUM_FWD*WIDTH-1:0]   fwd_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [WIDTH-1:0]           out_data;
    logic                       out_fwd;
    logic [CNT_W-1:0]           stall_cnt;

    modport master (
        output in_valid, sel, src, rs_addr, fwd_valid, fwd_busy, fwd_addr, fwd_data, out_ready,
        input  in_ready, out_valid, out_data, out_fwd, stall_cnt
    );
    modport slave (
        input  in_valid, sel, src, rs_addr, fwd_valid, fwd_busy, fwd_addr, fwd_data, out_ready,
        output in_ready, out_valid, out_data, out_fwd, stall_cnt
    );
endinterface

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: registered operand-B select with forwarding, load-use stall and stall counter.
// ALU_OPERAND_SKID_EN adds a second (skid) entry so in_ready no longer depends on out_ready.
module alu_operand_stage #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 4,
    parameter int NUM_FWD = 2,
    parameter int REG_AW  = 5,
    parameter int CNT_W   = 16
) (
    input logic clk,
    input logic reset,
    alu_operand_stage_if.slave bus
);
    localparam int SEL_W = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
    localparam logic [SEL_W:0] N_SRC = (SEL_W+1)'(NUM_SRC);

    logic [WIDTH-1:0] src_a [NUM_SRC];
    logic [SEL_W-1:0] eff_sel;
    logic             hit, busy, use_fwd, hazard, fwd, accept;
    logic [WIDTH-1:0] fwd_d, operand;

    genvar k;
    generate
        for (k = 0; k < NUM_SRC; k++) begin : g_src
            assign src_a[k] = bus.src[k*WIDTH +: WIDTH];
        end
    endgenerate

    assign eff_sel = {1'b0, bus.sel} < N_SRC ? bus.sel : '0;

    // Scan oldest to youngest so the youngest (lowest index) match is left standing.
    always_comb begin
        hit   = 1'b0;
        busy  = 1'b0;
        fwd_d = '0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if ((bus.fwd_valid[i] || bus.fwd_busy[i]) && bus.fwd_addr[i*REG_AW +: REG_AW] == bus.rs_addr) begin
                hit   = 1'b1;
                busy  = bus.fwd_busy[i];
                fwd_d = bus.fwd_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign use_fwd = eff_sel == '0 && bus.rs_addr != '0;
    assign hazard  = use_fwd && hit && busy;
    assign fwd     = use_fwd && hit && !busy;
    assign operand = fwd ? fwd_d : src_a[eff_sel];
    assign accept  = bus.in_valid && bus.in_ready;

`ifdef ALU_OPERAND_SKID_EN
    logic             skid_valid, skid_fwd;
    logic [WIDTH-1:0] skid_data;

    assign bus.in_ready = !hazard && !skid_valid;

    // An accept is only possible with the skid entry empty, so draining never races a skid fill.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_fwd   <= 1'b0;
            skid_valid    <= 1'b0;
            skid_data     <= '0;
            skid_fwd      <= 1'b0;
        end else if (bus.out_valid && !bus.out_ready) begin
            if (accept) begin
                skid_valid <= 1'b1;
                skid_data  <= operand;
                skid_fwd   <= fwd;
            end
        end else begin
            bus.out_valid <= skid_valid || accept;
            skid_valid    <= 1'b0;
            if (skid_valid) begin
                bus.out_data <= skid_data;
                bus.out_fwd  <= skid_fwd;
            end else if (accept) begin
                bus.out_data <= operand;
                bus.out_fwd  <= fwd;
            end
        end
    end
`else
    assign bus.in_ready = !hazard && (!bus.out_valid || bus.out_ready);

    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_fwd   <= 1'b0;
        end else if (accept) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= operand;
            bus.out_fwd   <= fwd;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset)
            bus.stall_cnt <= '0;
        else if (bus.in_valid && hazard && bus.stall_cnt != '1)
            bus.stall_cnt <= bus.stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed steps with a scoreboard of expected operands, checked at each drain.
module tb_alu_operand_stage;
    localparam int W = 32, NS = 5, NF = 2, AW = 5, CW = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    alu_operand_stage_if #(.WIDTH(W), .NUM_SRC(NS), .NUM_FWD(NF), .REG_AW(AW), .CNT_W(CW)) bus ();
    alu_operand_stage #(.WIDTH(W), .NUM_SRC(NS), .NUM_FWD(NF), .REG_AW(AW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    logic [W:0] exp_q [$];
    logic [W:0] nxt;
    int checks = 0, passes = 0, fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare a draining operand, record an accepted one, then advance one clock.
    task automatic cyc();
        logic [W:0] e;
        #1;
        if (reset && bus.out_valid === 1'b1 && bus.out_ready) begin
            if (exp_q.size() == 0) chk("sb_unexpected_drain", 64'(exp_q.size()), 64'd1);
            else begin
                e = exp_q.pop_front();
                chk("sb_data", 64'(bus.out_data), 64'(e[W-1:0]));
                chk("sb_fwd", 64'(bus.out_fwd), 64'(e[W]));
            end
        end
        if (reset && bus.in_valid && bus.in_ready) exp_q.push_back(nxt);
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [2:0] s, input logic [AW-1:0] rs, input logic [W:0] e);
        bus.in_valid = 1'b1;
        bus.sel      = s;
        bus.rs_addr  = rs;
        nxt          = e;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bus.in_valid  = 1'b1;
        bus.sel       = '0;
        bus.rs_addr   = '0;
        bus.fwd_valid = '0;
        bus.fwd_busy  = '0;
        bus.fwd_addr  = '0;
        bus.fwd_data  = '0;
        bus.out_ready = 1'b1;
        nxt           = '0;
        for (int k = 0; k < NS; k++) bus.src[k*W +: W] = 32'h1000_0000 + 32'(k);
        bus.src[W +: W] = 32'h0000_1234;

        cyc();
        cyc();
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_data", 64'(bus.out_data), 64'd0);
        chk("rst_fwd", 64'(bus.out_fwd), 64'd0);
        chk("rst_cnt", 64'(bus.stall_cnt), 64'd0);

        reset = 1'b1;
        req(3'd1, 5'd0, {1'b0, 32'h0000_1234});
        cyc();
        chk("latency_valid", 64'(bus.out_valid), 64'd1);

        req(3'd7, 5'd0, {1'b0, 32'h1000_0000});
        cyc();

        bus.fwd_valid = 2'b11;
        bus.fwd_addr  = {5'd5, 5'd5};
        bus.fwd_data  = {32'hBBBB_BBBB, 32'hAAAA_AAAA};
        req(3'd0, 5'd5, {1'b1, 32'hAAAA_AAAA});
        cyc();
        req(3'd0, 5'd0, {1'b0, 32'h1000_0000});
        cyc();
        bus.fwd_valid = 2'b10;
        req(3'd0, 5'd5, {1'b1, 32'hBBBB_BBBB});
        cyc();

        bus.fwd_valid = 2'b00;
        bus.fwd_busy  = 2'b01;
        bus.fwd_addr  = {5'd9, 5'd0};
        req(3'd0, 5'd0, {1'b0, 32'h1000_0000});
        #1 chk("rs0_no_stall", 64'(bus.in_ready), 64'd1);
        cyc();

        bus.fwd_addr = {5'd9, 5'd3};
        req(3'd0, 5'd3, {1'b1, 32'h0000_0055});
        for (int i = 0; i < 3; i++) begin
            if (i == 2) bus.fwd_valid = 2'b01;
            #1 chk("loaduse_ready", 64'(bus.in_ready), 64'd0);
            cyc();
        end
        chk("stall_cnt_3", 64'(bus.stall_cnt), 64'd3);
        bus.fwd_busy  = 2'b00;
        bus.fwd_valid = 2'b01;
        bus.fwd_data  = {32'hBBBB_BBBB, 32'h0000_0055};
        #1 chk("loaduse_release", 64'(bus.in_ready), 64'd1);
        cyc();

        bus.fwd_valid = 2'b00;
        bus.fwd_busy  = 2'b01;
        for (int i = 0; i < 6; i++) cyc();
        chk("stall_cnt_sat", 64'(bus.stall_cnt), 64'd7);
        bus.fwd_busy = 2'b00;

`ifndef ALU_OPERAND_SKID_EN
        req(3'd2, 5'd0, {1'b0, 32'h1000_0002});
        cyc();
        bus.out_ready = 1'b0;
        req(3'd4, 5'd0, {1'b0, 32'h1000_0004});
        for (int i = 0; i < 5; i++) begin
            #1 chk("bp_ready", 64'(bus.in_ready), 64'd0);
            chk("bp_hold", 64'(bus.out_data), 64'h1000_0002);
            cyc();
        end
        bus.out_ready = 1'b1;
        #1 chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
        cyc();
        chk("bp_reload_valid", 64'(bus.out_valid), 64'd1);
`else
        bus.src[W +: W] = 32'h1;
        req(3'd1, 5'd0, {1'b0, 32'h1});
        cyc();
        bus.src[W +: W] = 32'h2;
        bus.out_ready = 1'b0;
        nxt = {1'b0, 32'h2};
        #1 chk("skid_accept", 64'(bus.in_ready), 64'd1);
        cyc();
        bus.src[W +: W] = 32'h3;
        nxt = {1'b0, 32'h3};
        #1 chk("skid_full", 64'(bus.in_ready), 64'd0);
        chk("skid_hold", 64'(bus.out_data), 64'h1);
        cyc();
        bus.out_ready = 1'b1;
        #1 chk("skid_still_full", 64'(bus.in_ready), 64'd0);
        cyc();
        #1 chk("skid_freed", 64'(bus.in_ready), 64'd1);
        cyc();
`endif
        bus.in_valid = 1'b0;
        cyc();
        cyc();
        chk("final_empty", 64'(bus.out_valid), 64'd0);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Parametrised, registered successor to the combinational ALU operand-B select.
- Selects one of NUM_SRC operand sources and applies register forwarding from NUM_FWD later pipeline stages.
- Detects load-use hazards and stalls. Presents the operand through a valid/ready pipeline register between decode and execute.
- Also keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
- WIDTH, 32, operand width in bits.
- NUM_SRC, 4, number of operand sources. Index 0 is the register-file source: rs2 / pc_plus_4 / imm / pc order is set by decoder encoding.
- NUM_FWD, 2, forwarding ports. Index 0 is the youngest stage and has highest priority.
- REG_AW, 5, register address width.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream operand request valid.
- in_ready  out  1  stage can accept a request.
- sel  in  $clog2(NUM_SRC)  source select.
- src  in  NUM_SRC*WIDTH  flattened sources; slice k is src[k*WIDTH +: WIDTH].
- rs_addr  in  REG_AW  register address for source 0.
- fwd_valid  in  NUM_FWD  forwarding stage holds a result that is ready.
- fwd_busy  in  NUM_FWD  forwarding stage will write rs but its data is not ready yet (load).
- fwd_addr  in  NUM_FWD*REG_AW  destination address per stage.
- fwd_data  in  NUM_FWD*WIDTH  result per stage.
- out_valid  out  1  operand register valid.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  registered operand.
- out_fwd  out  1  registered flag: the operand came from forwarding.
- stall_cnt  out  CNT_W  saturating count of hazard-stall cycles.

Behaviour:
- Reset (reset==0 at a clk edge): out_valid=0, out_data=0, out_fwd=0, stall_cnt=0. This takes priority over all other activity, including mid-transfer; any held operand is discarded.
- Source select: if sel>=NUM_SRC, use source 0.
- Forwarding applies only when the effective sel==0 and rs_addr!=0.
- Match i means (fwd_valid[i] or fwd_busy[i]) and fwd_addr[i]==rs_addr. The lowest matching i wins.
  - If the winner has fwd_busy[i]=1, a hazard exists.
  - Otherwise the operand is fwd_data[i] and fwd=1.
  - With no match, the operand is the src slice and fwd=0.
  - If both fwd_valid[i] and fwd_busy[i] are set, busy wins.
- Storage: one register, states EMPTY (out_valid=0) and FULL (out_valid=1).
  - in_ready = !hazard && (!out_valid || out_ready). This is combinational.
  - Accept happens when in_valid && in_ready: the register loads the operand and fwd, and out_valid=1.
  - Drain happens when out_valid && out_ready && !accept: out_valid goes to 0.
  - Simultaneous drain and accept: the register reloads and out_valid stays 1.
  - Latency is 1 cycle from accept to out_valid.
- Holding: while out_valid && !out_ready, out_data and out_fwd stay stable.
- stall_cnt increments on every cycle with in_valid && hazard, and saturates at all-ones.
- rs_addr==0 never forwards and never stalls.

Optional Feature:
- Macro ALU_OPERAND_SKID_EN.
- When defined: a second (skid) entry is added, and in_ready becomes a register equal to "skid entry empty" (still gated combinationally by !hazard).
  - An accept while FULL and !out_ready fills the skid entry.
  - On drain, the skid entry moves to the output register.
  - Ordering is strictly FIFO.
  - Reset clears both entries.
- When undefined: single register as above, with a combinational in_ready path from out_ready.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_valid=1 → out_valid=0, out_data=0, stall_cnt=0. Release → first accept yields out_valid=1 the next cycle.
- Select: sel=1, src slice1=0x0000_1234, out_ready=1 → out_data=0x0000_1234, out_fwd=0 after 1 cycle. sel=7 (out of range) → src slice0.
- Forward priority: sel=0, rs_addr=5, fwd_valid=2'b11, fwd_addr={5,5}, fwd_data0=0xAAAA_AAAA, fwd_data1=0xBBBB_BBBB → out_data=0xAAAA_AAAA, out_fwd=1. Same stimulus with rs_addr=0 → src slice0.
- Load-use: sel=0, rs_addr=3, fwd_busy[0]=1, fwd_addr0=3 for 3 cycles → in_ready=0 for 3 cycles, stall_cnt=3. On the 4th cycle fwd_valid[0]=1, fwd_data0=0x55 → accepted, out_data=0x55.
- Backpressure: out_ready=0 with a FULL register → in_ready=0 and out_data stable for 5 cycles. Raise out_ready with in_valid=1 → drain and accept in the same cycle, out_valid stays 1.
- Skid (ALU_OPERAND_SKID_EN): stream 0x1,0x2,0x3 with out_ready=0 on the cycle 0x2 arrives → output order 1,2,3, no loss; in_ready drops only once both entries are full.
